// File: rtl/seq_mul_reconstruct_if.sv
// Operand/result handshake bundle for the shift-add dividend reconstructor.
// master drives operands and result acceptance; slave is the multiplier.
interface seq_mul_reconstruct_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  y;
  logic [7:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;

  modport master (
    output in_valid,
    output q,
    output y,
    output r,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  x_out
  );

  modport slave (
    input  in_valid,
    input  q,
    input  y,
    input  r,
    input  out_ready,
    output in_ready,
    output out_valid,
    output x_out
  );
endinterface

// File: rtl/seq_mul_reconstruct.sv
// Sequential 8x8 shift-add multiplier rebuilding x = q*y + r, one multiplier bit per cycle.
// The low APPROX_COLS accumulator columns use approximate adder cells (sum=(a^b)|cin, cout=a&b).
module seq_mul_reconstruct #(
  parameter int APPROX_COLS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_mul_reconstruct_if.slave  bus
);

  localparam int APPROX_EFF = (APPROX_COLS > 16) ? 16 : ((APPROX_COLS < 0) ? 0 : APPROX_COLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  q_reg, q_next;
  logic [7:0]  y_reg, y_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] x_out_reg, x_out_next;
  logic [2:0]  cnt_reg, cnt_next;

  logic [15:0] addend;
  logic [15:0] add_sum;
  logic [15:0] carry;

  assign addend   = {8'h00, y_reg} << cnt_reg;
  assign carry[0] = 1'b0;

  // Ripple adder; the carry out of column 15 is dropped so results wrap modulo 2^16.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_col
      logic a_bit;
      logic b_bit;
      logic c_bit;
      assign a_bit = acc_reg[gi];
      assign b_bit = addend[gi];
      assign c_bit = carry[gi];

      if (gi < APPROX_EFF) begin : g_approx_sum
        assign add_sum[gi] = (a_bit ^ b_bit) | c_bit;
      end else begin : g_exact_sum
        assign add_sum[gi] = a_bit ^ b_bit ^ c_bit;
      end

      if (gi < 15) begin : g_chain
        if (gi < APPROX_EFF) begin : g_approx_carry
          assign carry[gi+1] = a_bit & b_bit;
        end else begin : g_exact_carry
          assign carry[gi+1] = (a_bit & b_bit) | (a_bit & c_bit) | (b_bit & c_bit);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      q_reg     <= 8'h00;
      y_reg     <= 8'h00;
      acc_reg   <= 16'h0000;
      x_out_reg <= 16'h0000;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      y_reg     <= y_next;
      acc_reg   <= acc_next;
      x_out_reg <= x_out_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    y_next     = y_reg;
    acc_next   = acc_reg;
    x_out_next = x_out_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          q_next     = bus.q;
          y_next     = bus.y;
          acc_next   = {8'h00, bus.r};
          cnt_next   = 3'd0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Always eight steps, even for zero multiplier bits, to keep latency fixed.
        if (q_reg[cnt_reg]) begin
          acc_next = add_sum;
        end
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'd7) begin
          x_out_next = q_reg[cnt_reg] ? add_sum : acc_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.x_out     = x_out_reg;

endmodule

// File: tb/tb_seq_mul_reconstruct.sv
// Directed and randomised checks of seq_mul_reconstruct: an exact instance and one with two
// approximate low columns, sharing clock and reset.
module tb_seq_mul_reconstruct;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_mul_reconstruct_if if0 ();
  seq_mul_reconstruct_if if2 ();

  seq_mul_reconstruct #(.APPROX_COLS(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  seq_mul_reconstruct #(.APPROX_COLS(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  // Reference adder: bit-serial over 16 columns, low n columns approximate.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b, input int n);
    logic [15:0] s;
    logic        c;
    c = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < n) begin
        s[k] = (a[k] ^ b[k]) | c;
        c    = a[k] & b[k];
      end else begin
        s[k] = a[k] ^ b[k] ^ c;
        c    = (a[k] & b[k]) | (a[k] & c) | (b[k] & c);
      end
    end
    return s;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [7:0] qa, input logic [7:0] ya,
                                          input logic [7:0] ra, input int n);
    logic [15:0] acc;
    logic [15:0] yy;
    acc = {8'h00, ra};
    yy  = {8'h00, ya};
    for (int i = 0; i < 8; i++) begin
      if (qa[i]) acc = ref_add(acc, yy << i, n);
    end
    return acc;
  endfunction

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? if0.out_valid : if2.out_valid;
  endfunction

  function automatic logic get_ir(input int sel);
    return (sel == 0) ? if0.in_ready : if2.in_ready;
  endfunction

  function automatic logic [15:0] get_x(input int sel);
    return (sel == 0) ? if0.x_out : if2.x_out;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] qa,
                        input logic [7:0] ya, input logic [7:0] ra);
    if (sel == 0) begin
      if0.in_valid = v; if0.q = qa; if0.y = ya; if0.r = ra;
    end else begin
      if2.in_valid = v; if2.q = qa; if2.y = ya; if2.r = ra;
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 0) if0.out_ready = v;
    else          if2.out_ready = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge with the DUT in IDLE; returns result and edges from accept.
  task automatic do_op(input int sel, input logic [7:0] qa, input logic [7:0] ya,
                       input logic [7:0] ra, input bit release_out,
                       output logic [15:0] xo, output int lat);
    set_in(sel, 1'b1, qa, ya, ra);
    tick();
    set_in(sel, 1'b0, 8'h00, 8'h00, 8'h00);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!get_ov(sel) && lat < 40);
    xo = get_x(sel);
    if (release_out) begin
      set_ordy(sel, 1'b1);
      tick();
      set_ordy(sel, 1'b0);
    end
    $display("txn dut=%0d q=%02h y=%02h r=%02h x_out=%04h lat=%0d", sel == 0 ? 0 : 2,
             qa, ya, ra, xo, lat);
  endtask

  task automatic check_op(input string name, input int sel, input logic [7:0] qa,
                          input logic [7:0] ya, input logic [7:0] ra, input logic [15:0] exp_x);
    logic [15:0] xo;
    int          lat;
    do_op(sel, qa, ya, ra, 1'b1, xo, lat);
    checks++;
    if (xo !== exp_x) begin
      failures++;
      $display("FAIL %s x_out: got %04h expected %04h", name, xo, exp_x);
    end
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL %s latency: got %0d expected 8", name, lat);
    end
    checks++;
    if (get_ov(sel) !== 1'b0 || get_ir(sel) !== 1'b1) begin
      failures++;
      $display("FAIL %s release: got out_valid=%0b in_ready=%0b expected 0/1", name,
               get_ov(sel), get_ir(sel));
    end
  endtask

  task automatic test_reset;
    set_in(0, 1'b0, 8'h00, 8'h00, 8'h00);
    set_in(2, 1'b0, 8'h00, 8'h00, 8'h00);
    set_ordy(0, 1'b0);
    set_ordy(2, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0 || if0.x_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: got in_ready=%0b out_valid=%0b x_out=%04h expected 1/0/0000",
               if0.in_ready, if0.out_valid, if0.x_out);
    end
  endtask

  task automatic test_exact;
    check_op("exact_0d_0b_05", 0, 8'h0D, 8'h0B, 8'h05, 16'h0094);
    check_op("exact_ff_ff_fe", 0, 8'hFF, 8'hFF, 8'hFE, 16'hFEFF);
    check_op("exact_max", 0, 8'hFF, 8'hFF, 8'hFF, 16'hFF00);
    check_op("exact_q_zero", 0, 8'h00, 8'hFF, 8'h07, 16'h0007);
    check_op("exact_q_msb", 0, 8'h80, 8'h01, 8'h00, 16'h0080);
  endtask

  task automatic test_reset_mid_run;
    set_in(0, 1'b1, 8'hA5, 8'h33, 8'h11);
    tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.x_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_run: got out_valid=%0b in_ready=%0b x_out=%04h expected 0/1/0000",
               if0.out_valid, if0.in_ready, if0.x_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_op("after_reset", 0, 8'h0D, 8'h0B, 8'h05, 16'h0094);
  endtask

  task automatic test_approx;
    check_op("approx_01_03_01", 2, 8'h01, 8'h03, 8'h01, 16'h0002);
    check_op("approx_01_07_01", 2, 8'h01, 8'h07, 8'h01, 16'h0006);
    check_op("approx_03_01_00", 2, 8'h03, 8'h01, 8'h00, 16'h0003);
  endtask

  task automatic test_back_to_back;
    logic [15:0] xo;
    int          lat;
    do_op(0, 8'h02, 8'h03, 8'h01, 1'b0, xo, lat);
    checks++;
    if (xo !== 16'h0007 || lat !== 8) begin
      failures++;
      $display("FAIL bp_first: got x_out=%04h lat=%0d expected 0007/8", xo, lat);
    end
    set_in(0, 1'b1, 8'h05, 8'h04, 8'h03);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (if0.x_out !== 16'h0007 || if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: got x_out=%04h in_ready=%0b out_valid=%0b expected 0007/0/1",
                 i, if0.x_out, if0.in_ready, if0.out_valid);
      end
    end
    set_ordy(0, 1'b1);
    tick();
    set_ordy(0, 1'b0);
    checks++;
    if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got out_valid=%0b in_ready=%0b expected 0/1",
               if0.out_valid, if0.in_ready);
    end
    tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (if0.in_ready !== 1'b0 || if0.x_out !== 16'h0007) begin
      failures++;
      $display("FAIL bp_accept: got in_ready=%0b x_out=%04h expected 0/0007",
               if0.in_ready, if0.x_out);
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!if0.out_valid && lat < 40);
    checks++;
    if (if0.x_out !== 16'h0017 || lat !== 8) begin
      failures++;
      $display("FAIL bp_second: got x_out=%04h lat=%0d expected 0017/8", if0.x_out, lat);
    end
    $display("txn dut=0 q=05 y=04 r=03 x_out=%04h lat=%0d", if0.x_out, lat);
    set_ordy(0, 1'b1);
    tick();
    set_ordy(0, 1'b0);
  endtask

  task automatic test_random;
    logic [7:0]  qa, ya, ra;
    logic [15:0] xo, exp_x;
    int          lat;
    for (int n = 0; n < 300; n++) begin
      ya = 8'($urandom_range(1, 255));
      qa = 8'($urandom_range(0, 255));
      ra = 8'($urandom_range(0, int'(ya) - 1));
      exp_x = 16'(int'(qa) * int'(ya) + int'(ra));
      do_op(0, qa, ya, ra, 1'b1, xo, lat);
      checks++;
      if (xo !== exp_x || lat !== 8) begin
        failures++;
        $display("FAIL rand_exact q=%02h y=%02h r=%02h: got %04h lat=%0d expected %04h lat=8",
                 qa, ya, ra, xo, lat, exp_x);
      end
    end
    for (int n = 0; n < 200; n++) begin
      qa = 8'($urandom_range(0, 255));
      ya = 8'($urandom_range(0, 255));
      ra = 8'($urandom_range(0, 255));
      exp_x = ref_mul(qa, ya, ra, 2);
      do_op(2, qa, ya, ra, 1'b1, xo, lat);
      checks++;
      if (xo !== exp_x || lat !== 8) begin
        failures++;
        $display("FAIL rand_approx q=%02h y=%02h r=%02h: got %04h lat=%0d expected %04h lat=8",
                 qa, ya, ra, xo, lat, exp_x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_reset_mid_run();
    test_approx();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
